// File: rtl/tft_rx_capture.sv
// Capture side of the TFT link: samples DE-mode RGB565, rebuilds pixel x/y,
// emits sof/eol markers and checks line/frame geometry for lock and errors.
module tft_rx_capture #(
  parameter int H_ACTIVE    = 480,
  parameter int V_ACTIVE    = 272,
  parameter bit SYNC_POL    = 1'b1,
  parameter int LOCK_FRAMES = 2
) (
  input  logic        clk_9m,
  input  logic        sys_rst,
  input  logic        hsync,
  input  logic        vsync,
  input  logic        tft_de,
  input  logic [15:0] tft_rgb,
  input  logic        err_clr,
  output logic        pix_valid,
  output logic [15:0] pix_data,
  output logic [9:0]  pix_x,
  output logic [9:0]  pix_y,
  output logic        sof,
  output logic        eol,
  output logic        locked,
  output logic        h_err,
  output logic        v_err,
  output logic [7:0]  frame_cnt
);
  localparam logic [9:0] H_ACT   = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT   = 10'(V_ACTIVE);
  localparam logic [7:0] LOCK_N  = 8'(LOCK_FRAMES);
  localparam logic [9:0] CNT_MAX = 10'h3FF;

  typedef enum logic [1:0] {WAIT_VS, WAIT_DE, ACTIVE, BLANK} state_t;

  function automatic logic [9:0] sat_inc(input logic [9:0] v);
    return (v == CNT_MAX) ? v : v + 10'd1;
  endfunction

  // Stage 1: input register plus previous-cycle copies for edge detection
  logic        hs_q, vs_q, vs_prev_q, de_q, de_prev_q;
  logic [15:0] rgb_q;

  always_ff @(posedge clk_9m) begin
    if (sys_rst) begin
      hs_q      <= 1'b0;
      vs_q      <= ~SYNC_POL;
      vs_prev_q <= ~SYNC_POL;
      de_q      <= 1'b0;
      de_prev_q <= 1'b0;
      rgb_q     <= '0;
    end else begin
      hs_q      <= hsync;
      vs_q      <= vsync;
      vs_prev_q <= vs_q;
      de_q      <= tft_de;
      de_prev_q <= de_q;
      rgb_q     <= tft_rgb;
    end
  end

  // hsync is kept for status visibility only; line boundaries come from DE
  logic unused_hs;
  assign unused_hs = hs_q;

  logic vs_edge, de_rise;
  assign vs_edge = (vs_q == SYNC_POL) && (vs_prev_q != SYNC_POL);
  assign de_rise = de_q && !de_prev_q;

  state_t      state_q, state_d;
  logic [9:0]  x_q, x_d, y_q, y_d, y_line;
  logic [7:0]  clean_q, clean_d, fcnt_q, fcnt_d;
  logic        bad_q, bad_d, locked_q, locked_d, h_err_q, v_err_q;
  logic        pix_in, line_end, frame_end, force_v, h_set, v_set, accept;

  always_comb begin
    state_d   = state_q;
    x_d       = x_q;
    y_d       = y_q;
    bad_d     = bad_q;
    clean_d   = clean_q;
    locked_d  = locked_q;
    fcnt_d    = fcnt_q;
    pix_in    = 1'b0;
    line_end  = 1'b0;
    frame_end = 1'b0;
    force_v   = 1'b0;
    h_set     = 1'b0;
    v_set     = 1'b0;
    accept    = 1'b0;
    y_line    = y_q;
    case (state_q)
      WAIT_VS: if (vs_edge) begin
        state_d = WAIT_DE;
        x_d     = '0;
        y_d     = '0;
        bad_d   = 1'b0;
      end
      WAIT_DE, BLANK: begin
        if (vs_edge) begin
          frame_end = 1'b1;
          state_d   = WAIT_DE;
        end else if (de_rise) begin
          pix_in  = 1'b1;
          state_d = ACTIVE;
        end
      end
      ACTIVE: begin
        // vsync inside a line: close the line, then the frame, as a forced error
        if (vs_edge) begin
          line_end  = 1'b1;
          frame_end = 1'b1;
          force_v   = 1'b1;
          state_d   = WAIT_DE;
        end else if (!de_q) begin
          line_end = 1'b1;
          state_d  = BLANK;
        end else begin
          pix_in = 1'b1;
        end
      end
      default: state_d = WAIT_VS;
    endcase

    if (pix_in) begin
      accept = (x_q < H_ACT) && (y_q < V_ACT);
      x_d    = sat_inc(x_q);
    end
    if (line_end) begin
      h_set  = (x_q != H_ACT);
      y_line = sat_inc(y_q);
      x_d    = '0;
      y_d    = y_line;
    end
    if (frame_end) begin
      v_set  = force_v || (y_line != V_ACT);
      fcnt_d = fcnt_q + 8'd1;
      if (bad_q || h_set || v_set) begin
        clean_d  = '0;
        locked_d = 1'b0;
      end else begin
        clean_d  = (clean_q >= LOCK_N) ? LOCK_N : clean_q + 8'd1;
        locked_d = (clean_d == LOCK_N);
      end
      x_d   = '0;
      y_d   = '0;
      bad_d = 1'b0;
    end else if (h_set) begin
      bad_d = 1'b1;
    end
  end

  always_ff @(posedge clk_9m) begin
    if (sys_rst) begin
      state_q  <= WAIT_VS;
      x_q      <= '0;
      y_q      <= '0;
      bad_q    <= 1'b0;
      clean_q  <= '0;
      locked_q <= 1'b0;
      fcnt_q   <= '0;
      h_err_q  <= 1'b0;
      v_err_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      x_q      <= x_d;
      y_q      <= y_d;
      bad_q    <= bad_d;
      clean_q  <= clean_d;
      locked_q <= locked_d;
      fcnt_q   <= fcnt_d;
      h_err_q  <= h_set | (h_err_q & ~err_clr);
      v_err_q  <= v_set | (v_err_q & ~err_clr);
    end
  end

  // Stage 2: pixel output; eol looks ahead one pixel at the raw DE input
  logic        pv_q, sof_q, eol_q;
  logic [15:0] pd_q;
  logic [9:0]  px_q, py_q;

  always_ff @(posedge clk_9m) begin
    if (sys_rst) begin
      pv_q  <= 1'b0;
      pd_q  <= '0;
      px_q  <= '0;
      py_q  <= '0;
      sof_q <= 1'b0;
      eol_q <= 1'b0;
    end else begin
      pv_q  <= accept;
      pd_q  <= rgb_q;
      px_q  <= x_q;
      py_q  <= y_q;
      sof_q <= accept && (x_q == '0) && (y_q == '0);
      eol_q <= accept && !tft_de;
    end
  end

  assign pix_valid = pv_q;
  assign pix_data  = pd_q;
  assign pix_x     = px_q;
  assign pix_y     = py_q;
  assign sof       = sof_q;
  assign eol       = eol_q;
  assign locked    = locked_q;
  assign h_err     = h_err_q;
  assign v_err     = v_err_q;
  assign frame_cnt = fcnt_q;
endmodule
